// File: rtl/axi4_stream_defs_pkg.sv
// Shared AXI4-Stream definitions: FIFO word field offsets, TX FSM encoding and default TDEST.
// The AXI4-Stream slave on the ingress side uses the same field offsets.
package axi4_stream_defs;

    localparam int DATA_MSB    = 127;
    localparam int KEEP_LSB    = 128;
    localparam int KEEP_GROUPS = 4;

    localparam logic [1:0] TDESTADDR_DEFAULT = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DRAIN  = 2'b10
    } tx_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry buffer between the FIFO read port and the stream output; exposes its occupancy
// so the read scheduler can keep the total of stored plus in-flight words within two.
module axis_skid_buffer #(
    parameter int WIDTH = 133
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the two storage entries are reset too, so tdata/tkeep read 0 out of reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking updates; every register here samples pre-edge values.
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head_data  = mem[rd_ptr];
    assign head_valid = (count != 2'd0);
    assign occupancy  = count;

endmodule

// File: rtl/axi4_stream_master.sv
// FIFO-to-AXI4-Stream transmitter: pops FIFO words and emits PKTLEN-beat packets with fixed TDEST.
// Optional AXIS_MASTER_STATS_EN adds the pkt_count and underrun outputs.
module axi4_stream_master
    import axi4_stream_defs::*;
#(
    parameter int         DATABUSWIDTH  = (DATA_MSB + 1) / 8,
    parameter int         TDESTWIDTH    = 2,
    parameter int         FIFODATAWIDTH = KEEP_LSB + KEEP_GROUPS,
    parameter logic [TDESTWIDTH-1:0] TDESTADDR = TDESTADDR_DEFAULT,
    parameter int         PKTLEN        = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DATABUSWIDTH*8-1:0]  m_axis_tdata,
    output logic [DATABUSWIDTH-1:0]    m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic [TDESTWIDTH-1:0]      m_axis_tdest,
    output logic                       fifo_rd_en,
    input  logic [FIFODATAWIDTH-1:0]   fifo_rd_data,
    input  logic                       fifo_empty_flag,
    output logic                       busy
`ifdef AXIS_MASTER_STATS_EN
    ,
    output logic [15:0]                pkt_count,
    output logic [0:0]                 underrun
`endif
);

    localparam int DW          = DATABUSWIDTH * 8;
    localparam int GROUPS      = FIFODATAWIDTH - DW;
    localparam int GROUP_BYTES = DATABUSWIDTH / GROUPS;
    localparam int BW          = FIFODATAWIDTH + 1;

    tx_state_e        state;
    tx_state_e        next_state;
    logic [7:0]       issue_cnt;
    logic             rd_pending;
    logic             rd_pending_last;
    logic [BW-1:0]    head;
    logic             head_valid;
    logic [1:0]       occupancy;
    logic             xfer;
    logic             issue_last;
    logic             credit_ok;

    assign xfer       = head_valid & m_axis_tready;
    assign issue_last = (issue_cnt == 8'(PKTLEN - 1));
    // A beat leaving this cycle frees a slot, which keeps the read stream at one word per clock.
    assign credit_ok  = (3'(occupancy) + 3'(rd_pending)) < (3'd2 + 3'(xfer));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (enable && !fifo_empty_flag)    next_state = STREAM;
            STREAM:  if (fifo_rd_en && issue_last)      next_state = DRAIN;
            DRAIN:   if (xfer && head[BW-1])            next_state = IDLE;
            default:                                    next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        fifo_rd_en = (state == STREAM) && !fifo_empty_flag && credit_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_cnt       <= 8'd0;
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
        end else begin
            rd_pending      <= fifo_rd_en;
            rd_pending_last <= fifo_rd_en & issue_last;
            if (fifo_rd_en) begin
                issue_cnt <= issue_last ? 8'd0 : issue_cnt + 8'd1;
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH (BW)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (rd_pending),
        .push_data  ({rd_pending_last, fifo_rd_data}),
        .pop        (xfer),
        .head_data  (head),
        .head_valid (head_valid),
        .occupancy  (occupancy)
    );

    assign m_axis_tvalid = head_valid;
    assign m_axis_tdata  = head[DW-1:0];
    assign m_axis_tlast  = head_valid & head[BW-1];
    assign m_axis_tdest  = TDESTADDR;

    always_comb begin
        m_axis_tkeep = '0;
        for (int g = 0; g < GROUPS; g++) begin
            m_axis_tkeep[g*GROUP_BYTES +: GROUP_BYTES] = {GROUP_BYTES{head[DW+g]}};
        end
    end

`ifdef AXIS_MASTER_STATS_EN
    logic tvalid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count <= 16'd0;
            tvalid_q  <= 1'b0;
        end else begin
            tvalid_q <= head_valid;
            if (xfer && m_axis_tlast) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    // A fall of tvalid with the packet still open can only come from the FIFO running dry.
    assign underrun = tvalid_q & ~head_valid & busy;
`endif

endmodule
